wide_add_sequencer: RTL and testbench

//   Multi-cycle controller that runs one shared N-bit adder (carrybypassAdder or ripple_carry_adder)

---
 rtl/wide_add_sequencer.sv | 136 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Sequences one shared N-bit adder over WORDS words to form an N*WORDS-bit add.
// Optional WIDE_ADD_SUB_EN adds the in_sub port for A-B via inverted B and carry-in 1.
module wide_add_sequencer #(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   in_a,
  input  logic [N*WORDS-1:0]   in_b,
  input  logic                 in_cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                 in_sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout
);

  localparam int W    = N * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [W-1:0]      r_a, r_b, r_sum;
  logic              r_cout, r_ovf;
  logic              w_sub, w_last;
  logic [N-1:0]      w_a_word, w_b_word;

`ifdef WIDE_ADD_SUB_EN
  logic r_sub;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_sub <= 1'b0;
    else if (r_state == S_IDLE && in_valid)   r_sub <= in_sub;
  end
  assign w_sub = r_sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_a_word = r_a[r_idx*N +: N];
  assign w_b_word = r_b[r_idx*N +: N] ^ {N{w_sub}};
  assign w_last   = (r_idx == IDXW'(WORDS - 1));

  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        add_a   = w_a_word;
        add_b   = w_b_word;
        add_cin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Overflow uses the effective (possibly inverted) B msb seen by the adder on the top word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_idx   <= '0;
`ifdef WIDE_ADD_SUB_EN
            r_carry <= in_sub ? 1'b1 : in_cin;
`else
            r_carry <= in_cin;
`endif
          end
        end
        S_RUN: begin
          r_sum[r_idx*N +: N] <= add_sum;
          r_carry             <= add_cout;
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= add_cout;
            r_ovf  <= (w_a_word[N-1] == w_b_word[N-1]) && (add_sum[N-1] != w_a_word[N-1]);
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (N=32, WORDS=4) with a behavioural shared adder.
module tb_wide_add_sequencer;

  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_cin;
  logic [W-1:0]   in_a, in_b;
`ifdef WIDE_ADD_SUB_EN
  logic           in_sub;
`endif
  logic           out_valid, out_ready, out_cout, out_ovf, busy;
  logic [W-1:0]   out_sum;
  logic [N-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (N+1)'(add_cin);

  wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef WIDE_ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         c, o;
  } vec_t;

  task automatic check(input string nm, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: whole-operand arithmetic, two's-complement subtract as A + ~B + 1.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic cin, sub);
    logic [W-1:0] bb;
    logic         c0, ovf;
    logic [W:0]   t;
    bb  = sub ? ~b : b;
    c0  = sub ? 1'b1 : cin;
    t   = {1'b0, a} + {1'b0, bb} + (W+1)'(c0);
    ovf = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t};
  endfunction

  task automatic drive_req(input logic [W-1:0] a, b, input logic cin, sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef WIDE_ADD_SUB_EN
    in_sub   = sub;
`endif
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, b, input logic cin, sub,
                        input logic [W-1:0] es, input logic ec, eo);
    int wt;
    int lat;
    logic [N-1:0] a0, b0;
    wt = 0;
    while (!in_ready && wt < 20) begin @(negedge clk); wt++; end
    check({tag, " in_ready"}, (W+1)'(in_ready), (W+1)'(1));
    drive_req(a, b, cin, sub);
    @(negedge clk);
    in_valid = 1'b0;
    a0 = a[N-1:0];
    b0 = sub ? ~b[N-1:0] : b[N-1:0];
    check({tag, " add_a w0"}, (W+1)'(add_a), (W+1)'(a0));
    check({tag, " add_b w0"}, (W+1)'(add_b), (W+1)'(b0));
    check({tag, " add_cin w0"}, (W+1)'(add_cin), (W+1)'(sub ? 1'b1 : cin));
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, " latency"}, (W+1)'(lat), (W+1)'(WORDS));
    check({tag, " sum"}, {1'b0, out_sum}, {1'b0, es});
    check({tag, " cout"}, (W+1)'(out_cout), (W+1)'(ec));
    check({tag, " ovf"}, (W+1)'(out_ovf), (W+1)'(eo));
    check({tag, " done idle adder"}, (W+1)'({add_a, add_b, add_cin}), '0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " drained"}, (W+1)'({out_valid, busy, in_ready}), (W+1)'(3'b001));
  endtask

`ifdef WIDE_ADD_SUB_EN
  localparam int NV = 7;
`else
  localparam int NV = 5;
`endif

  initial begin
    vec_t tbl [NV];
    logic [W-1:0] ra, rb, hold_sum;
    logic [W+1:0] m;
    logic rc, rs;

    tbl[0] = '{'1, 128'd1, 1'b0, 1'b0, '0, 1'b1, 1'b0};
    tbl[1] = '{128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, '0, 1'b1, 1'b0,
               128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0};
    tbl[2] = '{128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
               128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1};
    tbl[3] = '{128'h80000000_00000000_00000000_00000000, 128'h80000000_00000000_00000000_00000000,
               1'b0, 1'b0, '0, 1'b1, 1'b1};
    tbl[4] = '{128'd3, 128'd4, 1'b1, 1'b0, 128'd8, 1'b0, 1'b0};
`ifdef WIDE_ADD_SUB_EN
    tbl[5] = '{128'd5, 128'd7, 1'b1, 1'b1, {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0};
    tbl[6] = '{128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0};
    in_sub = 1'b0;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset flags", (W+1)'({in_ready, out_valid, busy, out_cout, out_ovf}), (W+1)'(5'b10000));
    check("reset sum", {1'b0, out_sum}, '0);
    check("reset adder drive", (W+1)'({add_a, add_b, add_cin}), '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
             tbl[i].s, tbl[i].c, tbl[i].o);

    // Backpressure: result held while out_ready=0, in_valid ignored in DONE.
    drive_req(128'h1234, 128'h1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 30 && !out_valid; k++) @(negedge clk);
    check("bp valid", (W+1)'(out_valid), (W+1)'(1));
    hold_sum = out_sum;
    check("bp sum", {1'b0, hold_sum}, (W+1)'(128'h1235));
    for (int k = 0; k < 5; k++) begin
      drive_req('1, '1, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("bp hold %0d", k), (W+1)'({out_valid, in_ready, busy}), (W+1)'(3'b101));
      check($sformatf("bp stable %0d", k), {1'b0, out_sum}, {1'b0, hold_sum});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp drain", (W+1)'({out_valid, in_ready, busy}), (W+1)'(3'b010));
    @(negedge clk);
    check("bp no accept", (W+1)'({in_ready, busy}), (W+1)'(2'b10));

    // Reset two cycles into RUN abandons the op.
    drive_req('1, '1, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun rst flags", (W+1)'({out_valid, in_ready, busy}), (W+1)'(3'b010));
    check("midrun rst sum", {1'b0, out_sum}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post-rst", 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      for (int w = 0; w < WORDS; w++) begin
        int unsigned pa, pb;
        pa = $urandom_range(0, 3);
        pb = $urandom_range(0, 3);
        ra[w*N +: N] = (pa == 0) ? '1 : (pa == 1) ? '0 : N'($urandom);
        rb[w*N +: N] = (pb == 0) ? '1 : (pb == 1) ? '0 : N'($urandom);
      end
      rc = 1'($urandom);
`ifdef WIDE_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      m = model(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, m[W-1:0], m[W], m[W+1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
